// File: rtl/dlfloat_mult_pipe.sv
// Pipelined DLFloat multiplier: S1 unpack/classify, S2 mantissa multiply,
// S3 normalise/round/pack. One global stall derived from output back-pressure.
module dlfloat_mult_pipe #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic                 in_rnd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_res,
    output logic [3:0]           out_flags
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int MW   = MAN_W + 1;
    localparam int PW   = 2 * MW;
    localparam int EW   = EXP_W + 2;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
    localparam logic signed [EW-1:0] EMAX_E = EW'((1 << EXP_W) - 1);

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // ---------------- S1: unpack / classify ----------------
    logic             sign_a, sign_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] man_a, man_b;
    logic             nan_a, nan_b, zero_a, zero_b;

    assign {sign_a, exp_a, man_a} = in_a;
    assign {sign_b, exp_b, man_b} = in_b;

    assign nan_a  = (&exp_a) && (&man_a);
    assign nan_b  = (&exp_b) && (&man_b);
    assign zero_a = (exp_a == '0);
    assign zero_b = (exp_b == '0);

    logic                 s1_valid;
    logic                 s1_sign;
    logic signed [EW-1:0] s1_exp;
    logic [MW-1:0]        s1_ma, s1_mb;
    logic                 s1_nan, s1_zero, s1_rnd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_ma    <= '0;
            s1_mb    <= '0;
            s1_nan   <= 1'b0;
            s1_zero  <= 1'b0;
            s1_rnd   <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= sign_a ^ sign_b;
                s1_exp  <= $signed(EW'(exp_a)) + $signed(EW'(exp_b)) - BIAS_E;
                s1_ma   <= {1'b1, man_a};
                s1_mb   <= {1'b1, man_b};
                s1_nan  <= nan_a || nan_b;
                s1_zero <= zero_a || zero_b;
                s1_rnd  <= in_rnd;
            end
        end
    end

    // ---------------- S2: mantissa multiply ----------------
    logic                 s2_valid;
    logic                 s2_sign;
    logic signed [EW-1:0] s2_exp;
    logic [PW-1:0]        s2_prod;
    logic                 s2_nan, s2_zero, s2_rnd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_exp   <= '0;
            s2_prod  <= '0;
            s2_nan   <= 1'b0;
            s2_zero  <= 1'b0;
            s2_rnd   <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign <= s1_sign;
                s2_exp  <= s1_exp;
                s2_prod <= PW'(s1_ma) * PW'(s1_mb);
                s2_nan  <= s1_nan;
                s2_zero <= s1_zero;
                s2_rnd  <= s1_rnd;
            end
        end
    end

    // ---------------- S3: normalise / round / pack ----------------
    logic [MAN_W-1:0]     man_t;
    logic                 guard, sticky, inc, carry;
    logic [MW-1:0]        man_r;
    logic [MAN_W-1:0]     man_f;
    logic signed [EW-1:0] adj, exp_r;
    logic                 ovf, unf;
    logic [W-1:0]         res_d;
    logic [3:0]           flags_d;

    always_comb begin
        // Leading one sits at PW-1 or PW-2; pick mantissa/guard/sticky windows accordingly
        if (s2_prod[PW-1]) begin
            man_t  = s2_prod[PW-2 -: MAN_W];
            guard  = s2_prod[MAN_W];
            sticky = |s2_prod[MAN_W-1:0];
        end else begin
            man_t  = s2_prod[PW-3 -: MAN_W];
            guard  = s2_prod[MAN_W-1];
            sticky = |s2_prod[MAN_W-2:0];
        end

        inc   = !s2_rnd && guard && (sticky || man_t[0]);
        man_r = {1'b0, man_t} + MW'(inc);
        carry = man_r[MAN_W];
        man_f = carry ? '0 : man_r[MAN_W-1:0];

        adj   = EW'(s2_prod[PW-1]) + EW'(carry);
        exp_r = s2_exp + adj;

        ovf = (exp_r > EMAX_E) || ((exp_r == EMAX_E) && (&man_f));
        unf = exp_r[EW-1] || (exp_r == '0);

        res_d   = '0;
        flags_d = '0;
        if (s2_nan) begin
            res_d   = '1;
            flags_d = 4'b1000;
        end else if (s2_zero) begin
            res_d   = '0;
            flags_d = 4'b0000;
        end else if (ovf) begin
            res_d   = {s2_sign, {EXP_W{1'b1}}, {(MAN_W-1){1'b1}}, 1'b0};
            flags_d = 4'b0101;
        end else if (unf) begin
            res_d   = '0;
            flags_d = 4'b0011;
        end else begin
            res_d   = {s2_sign, exp_r[EXP_W-1:0], man_f};
            flags_d = {3'b000, guard || sticky};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_res   <= '0;
            out_flags <= '0;
        end else if (advance) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_res   <= res_d;
                out_flags <= flags_d;
            end
        end
    end

endmodule

// File: tb/tb_dlfloat_mult_pipe.sv
// Self-checking bench for dlfloat_mult_pipe: directed vectors, random stream with
// back-pressure, full-pipe stall and mid-flight reset, against an arithmetic model.
module tb_dlfloat_mult_pipe;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        rnd;
        logic [19:0] res;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_rnd;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_res;
    logic [3:0]  out_flags;

    int   checks = 0;
    int   failures = 0;
    bit   rand_ready = 1'b0;
    txn_t exp_q[$];

    always #5 clk = ~clk;

    dlfloat_mult_pipe #(.EXP_W(6), .MAN_W(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_rnd    (in_rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_flags (out_flags)
    );

    // Reference: exact integer product, rounded by comparing the discarded remainder to half an ulp.
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic rnd);
        int     ea, eb, e, k;
        longint p, q, rem, half;
        logic   s, nx;
        logic [5:0] eo;
        logic [8:0] mo;
        ea = int'(a[14:9]);
        eb = int'(b[14:9]);
        if ((ea == 63 && a[8:0] == 9'h1FF) || (eb == 63 && b[8:0] == 9'h1FF))
            return {16'hFFFF, 4'b1000};
        if (ea == 0 || eb == 0)
            return 20'h0;
        s = a[15] ^ b[15];
        p = longint'(512 + int'(a[8:0])) * longint'(512 + int'(b[8:0]));
        e = ea + eb - 31;
        k = (p >= longint'(524288)) ? 10 : 9;
        if (k == 10) e++;
        q    = p >> k;
        rem  = p - (q << k);
        half = longint'(1) << (k - 1);
        nx   = (rem != 0);
        if (!rnd && (rem > half || (rem == half && q[0]))) q++;
        if (q == longint'(1024)) begin
            q = 512;
            e++;
        end
        if (e > 63 || (e == 63 && q == longint'(1023)))
            return {s, 6'h3F, 9'h1FE, 4'b0101};
        if (e <= 0)
            return {16'h0, 4'b0011};
        eo = e[5:0];
        mo = q[8:0];
        return {s, eo, mo, 3'b000, nx};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        v = 16'($urandom);
        if ($urandom_range(0, 3) != 0) v[14:9] = 6'($urandom_range(25, 37));
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Scoreboard: every output transfer must match the oldest outstanding expectation,
    // and a stalled output must not change.
    logic        stall_prev = 1'b0;
    logic [19:0] held = '0;
    always @(negedge clk) begin
        txn_t t;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("hold_stable", 32'({out_valid, out_res, out_flags}), 32'({1'b1, held}));
            if (out_valid && out_ready) begin
                chk("result_expected", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    t = exp_q.pop_front();
                    checks++;
                    assert ({out_res, out_flags} === t.res) else begin
                        failures++;
                        $error("FAIL result a=%h b=%h rnd=%0d got=%h want=%h",
                               t.a, t.b, t.rnd, {out_res, out_flags}, t.res);
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_res, out_flags};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic rnd, input logic [19:0] want);
        txn_t t;
        t.a   = a;
        t.b   = b;
        t.rnd = rnd;
        t.res = want;
        exp_q.push_back(t);
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the operands.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic rnd, input logic [19:0] want);
        int n;
        in_a     = a;
        in_b     = b;
        in_rnd   = rnd;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            step();
            n++;
            if (n > 100) begin
                chk("accept_timeout", 32'(in_ready), 32'(1));
                in_valid = 1'b0;
                return;
            end
        end
        push(a, b, rnd, want);
        step();
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic latency_check(input logic [15:0] a, input logic [15:0] b, input logic rnd, input logic [19:0] want);
        in_a     = a;
        in_b     = b;
        in_rnd   = rnd;
        in_valid = 1'b1;
        @(negedge clk);
        chk("lat_in_ready", 32'(in_ready), 32'(1));
        push(a, b, rnd, want);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1", 32'(out_valid), 32'(0));
        @(negedge clk);
        chk("lat_cycle2", 32'(out_valid), 32'(0));
        @(negedge clk);
        chk("lat_cycle3", 32'(out_valid), 32'(1));
        step();
    endtask

    logic [15:0] dir_a [16] = '{16'h3E01, 16'h3E01, 16'h7E00, 16'h0200, 16'hFFFF, 16'h8000, 16'h7DFF, 16'h7C00,
                                16'h0200, 16'h0200, 16'h3ED4, 16'h3ED4, 16'hBF00, 16'h7FFF, 16'hFE00, 16'h8200};
    logic [15:0] dir_b [16] = '{16'h3F00, 16'h3F00, 16'h4000, 16'h0200, 16'h0000, 16'h3E00, 16'h4000, 16'h4000,
                                16'h3C00, 16'h3E00, 16'h3ED4, 16'h3ED4, 16'h3F00, 16'h3F00, 16'h4000, 16'h0200};
    logic        dir_r [16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [19:0] dir_x [16] = '{20'h3F021, 20'h3F011, 20'h7FFE5, 20'h00003, 20'hFFFF8, 20'h00000, 20'h7FFE5, 20'h7E000,
                                20'h00003, 20'h02000, 20'h40001, 20'h3FFF1, 20'hC0400, 20'hFFFF8, 20'hFFFE5, 20'h00003};

    initial begin
        logic [15:0] a, b;
        logic        r;

        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_rnd    = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("reset_out_valid", 32'(out_valid), 32'(0));
        chk("reset_out_res", 32'(out_res), 32'(0));
        chk("reset_out_flags", 32'(out_flags), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(in_ready), 32'(1));
        out_ready = 1'b1;
        step();

        // 1.5 x 1.5 with latency measurement
        latency_check(16'h3F00, 16'h3F00, 1'b0, {16'h4040, 4'b0000});

        // Directed vectors, back to back
        for (int i = 0; i < 16; i++) send(dir_a[i], dir_b[i], dir_r[i], dir_x[i]);
        drain();

        // Random stream with random gaps and random out_ready
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                step();
            end
            a = rand_op();
            b = rand_op();
            r = 1'($urandom_range(0, 1));
            send(a, b, r, model(a, b, r));
        end
        drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        step();

        // Fill the pipe with out_ready low, hold for 5 cycles, then release
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = rand_op();
            b = rand_op();
            r = 1'($urandom_range(0, 1));
            send(a, b, r, model(a, b, r));
        end
        a = rand_op();
        b = rand_op();
        r = 1'($urandom_range(0, 1));
        in_a     = a;
        in_b     = b;
        in_rnd   = r;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'(0));
            chk("stall_out_valid", 32'(out_valid), 32'(1));
            step();
        end
        out_ready = 1'b1;
        send(a, b, r, model(a, b, r));
        drain();

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            a = rand_op();
            b = rand_op();
            r = 1'($urandom_range(0, 1));
            send(a, b, r, model(a, b, r));
        end
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'(0));
        chk("midreset_out_res", 32'(out_res), 32'(0));
        chk("midreset_out_flags", 32'(out_flags), 32'(0));
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_reset_quiet", 32'(out_valid), 32'(0));
            step();
        end
        latency_check(16'h3E01, 16'h3F00, 1'b1, {16'h3F01, 4'b0001});
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
